mips_mem: RTL

MIPS_MEM -- requirements
Module: mips_mem

---
 rtl/mips_mem_if.sv | 24 ++
 rtl/mips_mem.sv | 103 ++++++++++
 2 files changed

// File: rtl/mips_mem_if.sv
// CPU and loader bus of the mips_mem block.
// The master drives CPU/loader requests; the slave (mips_mem) returns read data and status.
interface mips_mem_if #(parameter int WIDTH = 8);
    logic             memwrite;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] writedata;
    logic [WIDTH-1:0] memdata;
    logic             load_valid;
    logic [7:0]       load_data;
    logic             load_last;
    logic             load_ready;
    logic             cpu_reset;
    logic [WIDTH-1:0] out_port;

    modport master (
        output memwrite, addr, writedata, load_valid, load_data, load_last,
        input  memdata, load_ready, cpu_reset, out_port
    );

    modport slave (
        input  memwrite, addr, writedata, load_valid, load_data, load_last,
        output memdata, load_ready, cpu_reset, out_port
    );
endinterface

// File: rtl/mips_mem.sv
// Byte memory for a small MIPS core with a boot loader that streams the image in while the CPU is held in reset.
// Optional feature MIPS_MEM_MMIO_EN maps the top address onto the out_port register for CPU accesses.
module mips_mem #(
    parameter int WIDTH = 8
) (
    input logic       clk,
    input logic       reset,
    mips_mem_if.slave bus
);
    localparam int               DEPTH    = 1 << WIDTH;
    localparam logic [WIDTH-1:0] TOP_ADDR = {WIDTH{1'b1}};

    typedef enum logic [1:0] {LOAD, RELEASE, RUN} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] ptr, ptr_next;
    logic             rel_cnt, rel_cnt_next;
    logic             load_we;
    logic             cpu_we;
    logic             mmio_sel;
    logic [WIDTH-1:0] load_word;
    logic [WIDTH-1:0] mem [DEPTH];

    assign load_word = WIDTH'(bus.load_data);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= LOAD;
            ptr     <= '0;
            rel_cnt <= 1'b0;
        end else begin
            state   <= state_next;
            ptr     <= ptr_next;
            rel_cnt <= rel_cnt_next;
        end
    end

    // A full image (last address reached) ends loading even without load_last.
    always_comb begin
        state_next   = state;
        ptr_next     = ptr;
        rel_cnt_next = rel_cnt;
        load_we      = 1'b0;
        case (state)
            LOAD: begin
                if (bus.load_valid) begin
                    load_we  = 1'b1;
                    ptr_next = ptr + 1'b1;
                    if (bus.load_last || (ptr == TOP_ADDR)) begin
                        state_next = RELEASE;
                    end
                end
            end
            RELEASE: begin
                rel_cnt_next = ~rel_cnt;
                if (rel_cnt) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                state_next = RUN;
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    assign bus.cpu_reset  = (state != RUN);
    assign bus.load_ready = (state == LOAD);

`ifdef MIPS_MEM_MMIO_EN
    logic [WIDTH-1:0] out_reg;

    assign mmio_sel = (bus.addr == TOP_ADDR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_reg <= '0;
        end else if ((state == RUN) && bus.memwrite && mmio_sel) begin
            out_reg <= bus.writedata;
        end
    end

    assign bus.out_port = out_reg;
    assign bus.memdata  = mmio_sel ? out_reg : mem[bus.addr];
`else
    assign mmio_sel     = 1'b0;
    assign bus.out_port = '0;
    assign bus.memdata  = mem[bus.addr];
`endif

    assign cpu_we = (state == RUN) && bus.memwrite && !mmio_sel;

    // The array has no reset so an image survives a reset until overwritten.
    always_ff @(posedge clk) begin
        if (load_we) begin
            mem[ptr] <= load_word;
        end else if (cpu_we) begin
            mem[bus.addr] <= bus.writedata;
        end
    end
endmodule
